fifo_receiver: RTL
==================

Name: fifo_receiver

Overview:
- Read-side counterpart of the byte sender: drains an Intel-style single-clock FIFO (normal mode, data valid one cycle after read request) and parses framed byte packets.
- Emits payload bytes as a sop/eop-marked stream, checks length and checksum, and keeps frame/error statistics.
- Sits on the consumer clock domain, directly on the FIFO q/rdreq/empty side.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 64, largest legal payload length in bytes (1..255).
- TIMEOUT, 1024, idle cycles allowed mid-frame before abort (>=2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_q  in  8  FIFO read data, valid the cycle after fifo_rdreq.
- fifo_rdreq  out  1  FIFO read request.
- out_valid  out  1  payload byte valid (one-cycle qualifier).
- out_data  out  8  payload byte.
- out_sop  out  1  first payload byte of frame.
- out_eop  out  1  last payload byte of frame.
- frame_ok  out  1  one-cycle pulse, frame checksum matched.
- frame_err  out  1  one-cycle pulse, frame aborted.
- err_code  out  2  cause of last error: 0 none, 1 bad length, 2 bad checksum, 3 timeout; held until the next error or reset.
- frame_cnt  out  CNT_W  good frames received, saturating.
- err_cnt  out  CNT_W  aborted frames, saturating.

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, state HUNT, rd_valid 0, counters 0. Reset mid-frame discards the frame with no frame_err pulse.
- fifo_rdreq = !fifo_empty && !rst, combinational. rd_valid is fifo_rdreq registered. The parser consumes fifo_q only when rd_valid=1, so back-to-back reads give one byte per cycle.
- Frame format: SYNC, LEN, LEN payload bytes, CSUM. CSUM = 8-bit wrap-around sum of LEN and all payload bytes.
- FSM, advancing only on rd_valid:
  - HUNT: byte==SYNC_BYTE -> LEN; any other byte is discarded silently.
  - LEN: latch len, init sum=byte. Then:
    - len>MAX_LEN -> frame_err, err_code=1, HUNT.
    - len==0 -> CSUM.
    - otherwise -> PAYLOAD with remaining=len.
  - PAYLOAD: emit byte on out_* the same edge it is consumed (output registered, one cycle after rd_valid). sum+=byte. out_sop on the first byte; out_eop when remaining==1, then -> CSUM.
  - CSUM: byte==sum -> frame_ok, frame_cnt+1. Otherwise frame_err, err_code=2, err_cnt+1. Then -> HUNT.
- A length error also increments err_cnt.
- Timeout: in LEN/PAYLOAD/CSUM, a counter increments every cycle rd_valid=0 and clears on rd_valid=1. On reaching TIMEOUT: frame_err, err_code=3, err_cnt+1, -> HUNT. A partial payload already emitted is not retracted; out_eop is not issued.
- Payload with len=1: out_sop and out_eop both high on the same byte.
- A SYNC value inside payload/LEN/CSUM is data, not a resync.
- Counters saturate at all-ones; frame_ok and frame_err are never high in the same cycle.
- Frames are not validated before payload is forwarded; downstream uses frame_ok/frame_err to accept or discard.

Decomposition:
- Package fifo_link_pkg: SYNC_BYTE default, err_code enum (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT), rx state enum (HUNT, LEN, PAYLOAD, CSUM), checksum function. Shared with the sender for frame generation.
- Sub-module rx_timeout: loadable/clearable cycle counter with terminal pulse.

Test Plan:
- Stream A5 03 10 20 30 63, FIFO never empty -> out_data 10,20,30 on 3 consecutive cycles; sop on 10, eop on 30; frame_ok one cycle after the 63 is consumed; frame_cnt=1.
- Frame A5 03 10 20 30 64 -> payload emitted; frame_err, err_code=2, err_cnt=1, frame_cnt=0.
- Garbage 00 FF A4 then A5 00 00 -> no out_valid; frame_ok; frame_cnt=1.
- A5 41 with MAX_LEN=64 -> frame_err, err_code=1, next A5 01 7E 7F parsed OK, with 7E emitted as sop+eop.
- A5 05 01 02, then FIFO empty for TIMEOUT cycles -> two bytes emitted, frame_err, err_code=3; following valid frame received correctly.
- rst asserted for one cycle mid-PAYLOAD -> all outputs 0, counters 0, no frame_err; next frame parsed from HUNT; fifo_rdreq low while rst=1.

Source files
------------

// File: rtl/fifo_link_pkg.sv
// Shared definitions for the framed byte link: sync marker, error causes,
// receiver states and the frame checksum.
package fifo_link_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_CSUM    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2,
      CSUM    = 2'd3
   } rx_state_e;

   // Checksum is the 8-bit wrap-around sum of LEN and every payload byte.
   function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
      return sum + b;
   endfunction

endpackage

// File: rtl/fifo_receiver_if.sv
// FIFO read side plus the outgoing payload byte stream of the frame receiver.
interface fifo_receiver_if;
   // FIFO side: fifo_rdreq may only be high while fifo_empty is low; fifo_q
   // carries the requested byte on the following cycle. Stream side: out_valid
   // qualifies out_data/out_sop/out_eop for exactly one cycle, no backpressure.
   logic       fifo_empty;
   logic [7:0] fifo_q;
   logic       fifo_rdreq;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;

   modport master (
      input  fifo_empty, fifo_q,
      output fifo_rdreq, out_valid, out_data, out_sop, out_eop
   );

   modport slave (
      output fifo_empty, fifo_q,
      input  fifo_rdreq, out_valid, out_data, out_sop, out_eop
   );
endinterface

// File: rtl/fifo_receiver_rx_timeout.sv
// Idle-cycle counter: counts while enabled, clears on request, and pulses
// expire_o on the TIMEOUT-th consecutive enabled cycle.
module rx_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int             CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_receiver.sv
// Drains a normal-mode single-clock FIFO, parses SYNC/LEN/payload/CSUM frames,
// streams payload bytes and keeps good/aborted frame statistics.
module fifo_receiver
   import fifo_link_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_LEN   = 64,
   parameter int         TIMEOUT   = 1024,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   fifo_receiver_if.master  bus,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output rx_state_e        state_o
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   logic             rd_valid_q;
   rx_state_e        state_q, state_d;
   logic [7:0]       rem_q, rem_d, sum_q, sum_d, out_data_q, out_data_d;
   logic             first_q, first_d, out_valid_q, out_valid_d;
   logic             sop_q, sop_d, eop_q, eop_d, ok_q, ok_d, err_q, err_d;
   err_code_e        err_code_q, err_code_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d, ecnt_q, ecnt_d;
   logic             in_frame, tmo_expire;
   logic [7:0]       rx_byte;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Reset must block reads so no byte is popped and then lost during reset.
   assign bus.fifo_rdreq = !bus.fifo_empty && !rst;
   assign rx_byte        = bus.fifo_q;
   assign in_frame       = (state_q != HUNT);

   rx_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (rd_valid_q || !in_frame),
      .en_i     (in_frame && !rd_valid_q),
      .expire_o (tmo_expire)
   );

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      sum_d       = sum_q;
      first_d     = first_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      ok_d        = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      fcnt_d      = fcnt_q;
      ecnt_d      = ecnt_q;
      if (rd_valid_q) begin
         case (state_q)
            HUNT: begin
               if (rx_byte == SYNC_BYTE) state_d = LEN;
            end
            LEN: begin
               sum_d = rx_byte;
               if (rx_byte > MAX_LEN_B) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_LEN;
                  ecnt_d     = sat_inc(ecnt_q);
                  state_d    = HUNT;
               end else if (rx_byte == 8'd0) begin
                  state_d = CSUM;
               end else begin
                  rem_d   = rx_byte;
                  first_d = 1'b1;
                  state_d = PAYLOAD;
               end
            end
            PAYLOAD: begin
               out_valid_d = 1'b1;
               out_data_d  = rx_byte;
               sop_d       = first_q;
               eop_d       = (rem_q == 8'd1);
               first_d     = 1'b0;
               sum_d       = csum_add(sum_q, rx_byte);
               rem_d       = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = CSUM;
            end
            CSUM: begin
               if (rx_byte == sum_q) begin
                  ok_d   = 1'b1;
                  fcnt_d = sat_inc(fcnt_q);
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_CSUM;
                  ecnt_d     = sat_inc(ecnt_q);
               end
               state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end else if (tmo_expire) begin
         // Bytes already forwarded stay forwarded; the abort pulse tells downstream.
         err_d      = 1'b1;
         err_code_d = ERR_TIMEOUT;
         ecnt_d     = sat_inc(ecnt_q);
         state_d    = HUNT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q  <= 1'b0;
         state_q     <= HUNT;
         rem_q       <= '0;
         sum_q       <= '0;
         first_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         ok_q        <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
         fcnt_q      <= '0;
         ecnt_q      <= '0;
      end else begin
         rd_valid_q  <= bus.fifo_rdreq;
         state_q     <= state_d;
         rem_q       <= rem_d;
         sum_q       <= sum_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         ok_q        <= ok_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         fcnt_q      <= fcnt_d;
         ecnt_q      <= ecnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sop   = sop_q;
   assign bus.out_eop   = eop_q;
   assign frame_ok      = ok_q;
   assign frame_err     = err_q;
   assign err_code      = err_code_q;
   assign frame_cnt     = fcnt_q;
   assign err_cnt       = ecnt_q;
   assign state_o       = state_q;

endmodule
